// File: rtl/karatsuba_ctrl_pkg.sv
// Shared types and defaults for the Karatsuba multiplier arbiter.
// Imported by the arbiter top level.
package karatsuba_ctrl_pkg;

    localparam int N_DEF      = 32;
    localparam int SETTLE_DEF = 2;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        RESP
    } state_e;

endpackage

// File: rtl/karatsuba_32.sv
// Combinational 32x32 unsigned multiplier.
// Uses one Karatsuba level on 16-bit halves.
module karatsuba_32 (
    input  logic [31:0] X,
    input  logic [31:0] Y,
    output logic [63:0] Z
);

    logic [15:0] a1, a0, b1, b0;
    logic [31:0] z2, z0;
    logic [16:0] sa, sb;
    logic [33:0] m, z1;

    assign a1 = X[31:16];
    assign a0 = X[15:0];
    assign b1 = Y[31:16];
    assign b0 = Y[15:0];

    assign z2 = a1 * b1;
    assign z0 = a0 * b0;
    assign sa = {1'b0, a1} + {1'b0, a0};
    assign sb = {1'b0, b1} + {1'b0, b0};
    assign m  = {17'd0, sa} * {17'd0, sb};

    // Cross term a1*b0 + a0*b1 is always non-negative and below 2^33.
    assign z1 = m - {2'd0, z2} - {2'd0, z0};

    assign Z = {z2, z0} + {14'd0, z1, 16'd0};

endmodule

// File: rtl/rr_arb2.sv
// Two-request round-robin grant.
// Owns the last_grant register; ties go to the other requester.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;

    // A grant never looks at its own request, only at the competitor.
    always_comb begin
        gnt_o[0] = en_i & (~req_i[1] | last_q);
        gnt_o[1] = en_i & (~req_i[0] | ~last_q);
        last_d   = last_q;
        if (upd_i) begin
            last_d = req_i[1] & gnt_o[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/karatsuba_mul_arbiter.sv
// Shares one combinational karatsuba_32 between two requesters,
// holding captured operands for SETTLE cycles before sampling Z.
import karatsuba_ctrl_pkg::*;

module karatsuba_mul_arbiter #(
    parameter int N      = N_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_x,
    input  logic [N-1:0]   req0_y,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_x,
    input  logic [N-1:0]   req1_y,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [2*N-1:0] resp_z,
    output logic           resp_id,
    output logic           busy
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     x_q, x_d, y_q, y_d;
    logic [2*N-1:0]   z_q, z_d;
    logic             id_q, id_d;
    logic             rv_q, rv_d;
    logic [2*N-1:0]   mul_z;
    logic [1:0]       gnt, fire;
    logic             upd;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (state_q == IDLE),
        .req_i ({req1_valid, req0_valid}),
        .upd_i (upd),
        .gnt_o (gnt)
    );

    karatsuba_32 u_mul (
        .X (x_q),
        .Y (y_q),
        .Z (mul_z)
    );

    assign fire = gnt & {req1_valid, req0_valid};
    assign upd  = |fire;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        id_d    = id_q;
        rv_d    = rv_q;
        unique case (state_q)
            IDLE: begin
                if (upd) begin
                    x_d     = fire[1] ? req1_x : req0_x;
                    y_d     = fire[1] ? req1_y : req0_y;
                    id_d    = fire[1];
                    cnt_d   = CNT_INIT;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (cnt_q == '0) begin
                    z_d     = mul_z;
                    rv_d    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            id_q    <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            id_q    <= id_d;
            rv_q    <= rv_d;
        end
    end

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign resp_valid = rv_q;
    assign resp_z     = z_q;
    assign resp_id    = id_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_karatsuba_mul_arbiter.sv
// Directed-vector bench for karatsuba_mul_arbiter (N=32, SETTLE=2).
// Each task drives one scenario and checks against hand-computed values.
module tb_karatsuba_mul_arbiter;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_x, req0_y;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_x, req1_y;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_z;
    logic        resp_id;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    karatsuba_mul_arbiter #(.N(32), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_z     (resp_z),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    // Offer one pair, wait for acceptance, then wait for resp_valid.
    // Returns at 1ns after the edge where resp_valid is first seen.
    task automatic do_op(input bit k, input logic [31:0] x,
                         input logic [31:0] y, output logic [63:0] z,
                         output logic zid, output int lat, output bit ok);
        bit acc = 0;
        bit f;
        ok = 0;
        lat = 0;
        z = '0;
        zid = 1'b0;
        @(posedge clk);
        #1;
        if (k) begin
            req1_valid = 1; req1_x = x; req1_y = y;
        end else begin
            req0_valid = 1; req0_x = x; req0_y = y;
        end
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            f = k ? req1_ready : req0_ready;
            @(posedge clk);
            if (f) acc = 1;
        end
        #1;
        if (k) req1_valid = 0; else req0_valid = 0;
        if (!acc) return;
        while (!resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid) return;
        z = resp_z;
        zid = resp_id;
        ok = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #12;
        vectors++;
        if (resp_valid !== 1'b0 || resp_z !== 64'd0 ||
            resp_id !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b z=%h id=%b busy=%b want 0",
                     resp_valid, resp_z, resp_id, busy);
        end
        vectors++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_readies: got r0=%b r1=%b want 1 1",
                     req0_ready, req1_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_single();
        logic [63:0] z;
        logic zid;
        int lat;
        bit ok;
        do_op(0, 32'd3574846122, 32'd3807872197, z, zid, lat, ok);
        vectors++;
        if (!ok || z !== 64'd13612557156517070034 || zid !== 1'b0) begin
            miscompares++;
            $display("FAIL single: ok=%0d z=%0d id=%b want z=13612557156517070034 id=0",
                     ok, z, zid);
        end
        vectors++;
        if (lat != SETTLE) begin
            miscompares++;
            $display("FAIL single_latency: got %0d want %0d", lat, SETTLE);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_release: v=%b busy=%b want 0 0",
                     resp_valid, busy);
        end
    endtask

    task automatic test_full_width();
        logic [63:0] z;
        logic zid;
        int lat;
        bit ok;
        do_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, z, zid, lat, ok);
        vectors++;
        if (!ok || z !== 64'hFFFFFFFE00000001 || zid !== 1'b1) begin
            miscompares++;
            $display("FAIL full_width: ok=%0d z=%h id=%b want FFFFFFFE00000001 1",
                     ok, z, zid);
        end
        do_op(1, 32'd0, 32'hFFFFFFFF, z, zid, lat, ok);
        vectors++;
        if (!ok || z !== 64'd0 || zid !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_operand: ok=%0d z=%h id=%b want 0 1",
                     ok, z, zid);
        end
    endtask

    task automatic test_patterns();
        logic [31:0] xs [4] = '{32'd65536, 32'd65535, 32'h80000000, 32'd1000};
        logic [31:0] ys [4] = '{32'd65536, 32'd65537, 32'd2, 32'd999};
        logic [63:0] zs [4] = '{64'h100000000, 64'hFFFFFFFF,
                                64'h100000000, 64'd999000};
        logic [63:0] z;
        logic zid;
        int lat;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            do_op(i[0], xs[i], ys[i], z, zid, lat, ok);
            vectors++;
            if (!ok || z !== zs[i] || zid !== i[0]) begin
                miscompares++;
                $display("FAIL pattern%0d: z=%h id=%b want z=%h id=%b",
                         i, z, zid, zs[i], i[0]);
            end
        end
    endtask

    task automatic test_fairness();
        int lat;
        rst_n = 0;
        #3;
        rst_n = 1;
        @(posedge clk);
        #1;
        req0_valid = 1; req0_x = 32'd2; req0_y = 32'd3;
        req1_valid = 1; req1_x = 32'd5; req1_y = 32'd7;
        for (int k = 0; k < 4; k++) begin
            lat = 0;
            while (!resp_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            vectors++;
            if (!resp_valid || resp_id !== k[0] ||
                resp_z !== (k[0] ? 64'd35 : 64'd6)) begin
                miscompares++;
                $display("FAIL fairness%0d: v=%b id=%b z=%0d want id=%b z=%0d",
                         k, resp_valid, resp_id, resp_z, k[0],
                         k[0] ? 35 : 6);
            end
            vectors++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL fairness_ready%0d: r0=%b r1=%b want 0 0",
                         k, req0_ready, req1_ready);
            end
            @(posedge clk);
            #1;
        end
        req0_valid = 0;
        req1_valid = 0;
        repeat (SETTLE + 3) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [63:0] z;
        logic zid;
        int lat;
        bit ok;
        int bad = 0;
        resp_ready = 0;
        do_op(0, 32'd1234, 32'd5678, z, zid, lat, ok);
        vectors++;
        if (!ok || z !== 64'd7006652 || zid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_product: ok=%0d z=%0d id=%b want 7006652 0",
                     ok, z, zid);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid !== 1'b1 || resp_z !== 64'd7006652 ||
                resp_id !== 1'b0 || busy !== 1'b1 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
        end
        resp_ready = 1;
        @(posedge clk);
        #1;
        vectors++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: v=%b busy=%b want 0 0",
                     resp_valid, busy);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [63:0] z;
        logic zid;
        int lat;
        bit ok;
        int seen = 0;
        @(posedge clk);
        #1;
        req0_valid = 1; req0_x = 32'd100; req0_y = 32'd200;
        @(posedge clk);
        #1;
        req0_valid = 0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_accept: busy=%b want 1", busy);
        end
        @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        vectors++;
        if (resp_valid !== 1'b0 || resp_z !== 64'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_clear: v=%b z=%0d busy=%b want 0 0 0",
                     resp_valid, resp_z, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL midrst_discard: resp_valid seen %0d times, want 0",
                     seen);
        end
        do_op(1, 32'd9, 32'd11, z, zid, lat, ok);
        vectors++;
        if (!ok || z !== 64'd99 || zid !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_after: ok=%0d z=%0d id=%b want 99 1",
                     ok, z, zid);
        end
    endtask

    task automatic test_late_change();
        int lat = 0;
        @(posedge clk);
        #1;
        req0_valid = 1; req0_x = 32'd1000; req0_y = 32'd1000;
        #1;
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL late_ready: r0=%b want 1", req0_ready);
        end
        @(posedge clk);
        #1;
        req0_valid = 0; req0_x = 32'd7; req0_y = 32'd7;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (!resp_valid || resp_z !== 64'd1000000 || resp_id !== 1'b0) begin
            miscompares++;
            $display("FAIL late_change: v=%b z=%0d id=%b want 1 1000000 0",
                     resp_valid, resp_z, resp_id);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0;
        req0_valid = 0; req0_x = '0; req0_y = '0;
        req1_valid = 0; req1_x = '0; req1_y = '0;
        resp_ready = 1;
        test_reset();
        test_single();
        test_full_width();
        test_patterns();
        test_fairness();
        test_backpressure();
        test_reset_mid_op();
        test_late_change();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
